// File: rtl/note_sequencer.sv
// note_sequencer
// Walks a song table held in external ROM at a fixed tempo. For each note step
// it issues one pitch request to the pitch adjuster, waits for the adjusted
// pitch, then writes that pitch to a single ADPCM voice together with a key-on
// strobe. Rest steps, and steps whose note is above 11, produce key-off instead.
//
// Ports:
//   clk, reset_n            clock; synchronous active-low reset
//   enable                  run/stop level; a stop takes effect once the current
//                           note has finished
//   reference_pitch_in      pitch of C in octave 0
//   step_addr / step_data   song ROM address and data (data valid one cycle
//                           after the address); [7]=rest, [5:4]=octave,
//                           [3:0]=note
//   reference_pitch_valid   one-cycle request strobe to the pitch adjuster
//   reference_pitch, target_note, octave
//                           request operands; held until the next decode
//   adjusted_pitch(_valid)  adjuster result and its level valid
//   voice_pitch             pitch last written to the voice
//   voice_pitch_write, key_on
//                           coincident one-cycle strobes
//   key_off                 one-cycle key-off strobe
//   busy                    high while a step is being processed
module note_sequencer #(
  parameter int unsigned TICK_DIVIDER = 12000,
  parameter int unsigned STEP_COUNT   = 16,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [15:0]       reference_pitch_in,
  output logic [ADDR_W-1:0] step_addr,
  input  logic [7:0]        step_data,
  output logic              reference_pitch_valid,
  output logic [15:0]       reference_pitch,
  output logic [3:0]        target_note,
  output logic [1:0]        octave,
  input  logic [15:0]       adjusted_pitch,
  input  logic              adjusted_pitch_valid,
  output logic [15:0]       voice_pitch,
  output logic              voice_pitch_write,
  output logic              key_on,
  output logic              key_off,
  output logic              busy
);

  localparam int unsigned       CNT_W     = $clog2(TICK_DIVIDER);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIVIDER - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(STEP_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_REQUEST,
    ST_SETTLE,
    ST_WAIT,
    ST_WRITE,
    ST_HOLD
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             pending;
  logic             step_skip;
  logic             step_data_unused;

  // Bit 6 of the table entry carries no meaning for this block.
  assign step_data_unused = step_data[6];

  always_comb begin
    step_skip             = step_data[7] || (step_data[3:0] > 4'd11);
    tick                  = enable && (state != ST_IDLE) && (tick_cnt == CNT_LAST);
    state_next            = state;
    reference_pitch_valid = 1'b0;
    voice_pitch_write     = 1'b0;
    key_on                = 1'b0;
    key_off               = 1'b0;
    busy                  = (state != ST_IDLE) && (state != ST_HOLD);
    case (state)
      ST_IDLE:    if (enable) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_DECODE;
      ST_DECODE: begin
        if (step_skip) begin
          key_off    = 1'b1;
          state_next = ST_HOLD;
        end else begin
          state_next = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        reference_pitch_valid = 1'b1;
        state_next            = ST_SETTLE;
      end
      // The adjuster's valid from the previous note is still up here.
      ST_SETTLE:  state_next = ST_WAIT;
      ST_WAIT:    if (adjusted_pitch_valid) state_next = ST_WRITE;
      ST_WRITE: begin
        voice_pitch_write = 1'b1;
        key_on            = 1'b1;
        state_next        = ST_HOLD;
      end
      ST_HOLD: begin
        if (!enable) begin
          key_off    = 1'b1;
          state_next = ST_IDLE;
        end else if (tick || pending) begin
          state_next = ST_FETCH;
        end
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      step_addr       <= '0;
      tick_cnt        <= '0;
      pending         <= 1'b0;
      voice_pitch     <= '0;
      target_note     <= '0;
      octave          <= '0;
      reference_pitch <= '0;
    end else begin
      state <= state_next;

      if (!enable || (state == ST_IDLE) || tick) tick_cnt <= '0;
      else                                       tick_cnt <= tick_cnt + 1'b1;

      // A step that overruns its slot remembers at most one missed tick.
      if (state_next == ST_FETCH)          pending <= 1'b0;
      else if (tick && (state != ST_HOLD)) pending <= 1'b1;

      case (state)
        ST_IDLE: if (enable) step_addr <= '0;
        ST_DECODE: begin
          if (!step_skip) begin
            target_note     <= step_data[3:0];
            octave          <= step_data[5:4];
            reference_pitch <= reference_pitch_in;
          end
        end
        ST_WAIT: if (adjusted_pitch_valid) voice_pitch <= adjusted_pitch;
        ST_HOLD: begin
          if (!enable)                step_addr <= '0;
          else if (tick || pending)   step_addr <= (step_addr == ADDR_LAST) ? '0 : step_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
